// File: rtl/pkt_width_pkg.sv
// pkt_width_pkg: lane geometry and pack-state encoding shared by the
// narrow-to-wide packer and the wide-to-narrow adapter.
package pkt_width_pkg;

    typedef enum logic {IDLE, PACK} pack_state_e;

    function automatic int ratio_of(input int ow, input int iw);
        return ow / iw;
    endfunction

    function automatic int empty_w_of(input int ow, input int iw);
        return $clog2(ow / iw);
    endfunction

    // Lane 0 sits in the MSBs, so lane k's top bit counts down from OW-1.
    function automatic int lane_msb(input int k, input int ow, input int iw);
        return ow - 1 - k * iw;
    endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// pkt_out_reg: single-entry Avalon-ST output holding register with
// data/sop/eop/empty sideband; ready_o tells the producer it may load.
module pkt_out_reg #(
    parameter int DW = 256,
    parameter int EW = 3
) (
    input  logic          clock_clk,
    input  logic          reset_reset,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          sop_i,
    input  logic          eop_i,
    input  logic [EW-1:0] empty_i,
    input  logic          ready_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          sop_o,
    output logic          eop_o,
    output logic [EW-1:0] empty_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q;
    logic          sop_q, eop_q;
    logic [EW-1:0] empty_q;

    always_comb begin
        ready_o = !valid_q || ready_i;
        valid_d = load_i || (valid_q && !ready_i);
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q  <= data_i;
                sop_q   <= sop_i;
                eop_q   <= eop_i;
                empty_q <= empty_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/packet_symbol_packer.sv
// packet_symbol_packer: packs RATIO narrow Avalon-ST beats into one wide word,
// preserving sop/eop and reporting unused trailing lanes via empty.
module packet_symbol_packer
    import pkt_width_pkg::*;
#(
    parameter int  INPUT_SYMBOL_WIDTH  = 32,
    parameter int  OUTPUT_SYMBOL_WIDTH = 256,
    localparam int RATIO   = ratio_of(OUTPUT_SYMBOL_WIDTH, INPUT_SYMBOL_WIDTH),
    localparam int EMPTY_W = empty_w_of(OUTPUT_SYMBOL_WIDTH, INPUT_SYMBOL_WIDTH)
) (
    input  logic                           clock_clk,
    input  logic                           reset_reset,
    input  logic [INPUT_SYMBOL_WIDTH-1:0]  asi_in0_data,
    input  logic                           asi_in0_valid,
    output logic                           asi_in0_ready,
    input  logic                           asi_in0_startofpacket,
    input  logic                           asi_in0_endofpacket,
    output logic [OUTPUT_SYMBOL_WIDTH-1:0] aso_out0_data,
    output logic                           aso_out0_valid,
    input  logic                           aso_out0_ready,
    output logic                           aso_out0_startofpacket,
    output logic                           aso_out0_endofpacket,
    output logic [EMPTY_W-1:0]             aso_out0_empty,
    output logic [15:0]                    status_drop_count
);

    localparam int IW = INPUT_SYMBOL_WIDTH;
    localparam int OW = OUTPUT_SYMBOL_WIDTH;
    localparam logic [EMPTY_W-1:0] LAST = EMPTY_W'(RATIO - 1);

    pack_state_e        state_q, state_d;
    logic [EMPTY_W-1:0] cnt_q, cnt_d, lane, empty;
    logic [OW-1:0]      acc_q, acc_d, merged;
    logic               first_q, first_d, first_out;
    logic [15:0]        drop_q, drop_d;
    logic               accept, restart, take, complete, drop;

    always_comb begin
        accept    = asi_in0_valid && asi_in0_ready;
        restart   = accept && asi_in0_startofpacket;
        take      = restart || (accept && state_q == PACK);
        // Non-sop beat in IDLE, or sop that aborts an unfinished packet.
        drop      = accept && ((state_q == IDLE) ^ asi_in0_startofpacket);
        lane      = restart ? '0 : cnt_q;
        merged    = restart ? '0 : acc_q;
        for (int k = 0; k < RATIO; k++)
            if (EMPTY_W'(k) == lane) merged[lane_msb(k, OW, IW) -: IW] = asi_in0_data;
        complete  = take && (lane == LAST || asi_in0_endofpacket);
        empty     = asi_in0_endofpacket ? LAST - lane : '0;
        first_out = restart || first_q;
        state_d   = (complete && asi_in0_endofpacket) ? IDLE : take ? PACK : state_q;
        cnt_d     = complete ? '0 : take ? lane + EMPTY_W'(1) : cnt_q;
        acc_d     = complete ? '0 : take ? merged : acc_q;
        first_d   = complete ? 1'b0 : take ? first_out : first_q;
        drop_d    = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            first_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            first_q <= first_d;
            drop_q  <= drop_d;
        end
    end

    assign status_drop_count = drop_q;

    pkt_out_reg #(.DW(OW), .EW(EMPTY_W)) u_out (
        .clock_clk  (clock_clk),
        .reset_reset(reset_reset),
        .load_i     (complete),
        .data_i     (merged),
        .sop_i      (first_out),
        .eop_i      (asi_in0_endofpacket),
        .empty_i    (empty),
        .ready_i    (aso_out0_ready),
        .ready_o    (asi_in0_ready),
        .valid_o    (aso_out0_valid),
        .data_o     (aso_out0_data),
        .sop_o      (aso_out0_startofpacket),
        .eop_o      (aso_out0_endofpacket),
        .empty_o    (aso_out0_empty)
    );

endmodule

// File: tb/tb_packet_symbol_packer.sv
// tb_packet_symbol_packer: directed vectors for the 32-to-256 packer with
// hand-computed expected words, drop counts and stall behaviour.
module tb_packet_symbol_packer;

    localparam int IW = 32;
    localparam int OW = 256;
    localparam int EW = 3;

    logic          clock_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [IW-1:0] asi_in0_data = '0;
    logic          asi_in0_valid = 1'b0;
    logic          asi_in0_ready;
    logic          asi_in0_startofpacket = 1'b0;
    logic          asi_in0_endofpacket = 1'b0;
    logic [OW-1:0] aso_out0_data;
    logic          aso_out0_valid;
    logic          aso_out0_ready = 1'b1;
    logic          aso_out0_startofpacket;
    logic          aso_out0_endofpacket;
    logic [EW-1:0] aso_out0_empty;
    logic [15:0]   status_drop_count;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } word_t;

    word_t got[$];
    int    checks = 0;
    int    errors = 0;

    packet_symbol_packer dut (
        .clock_clk             (clock_clk),
        .reset_reset           (reset_reset),
        .asi_in0_data          (asi_in0_data),
        .asi_in0_valid         (asi_in0_valid),
        .asi_in0_ready         (asi_in0_ready),
        .asi_in0_startofpacket (asi_in0_startofpacket),
        .asi_in0_endofpacket   (asi_in0_endofpacket),
        .aso_out0_data         (aso_out0_data),
        .aso_out0_valid        (aso_out0_valid),
        .aso_out0_ready        (aso_out0_ready),
        .aso_out0_startofpacket(aso_out0_startofpacket),
        .aso_out0_endofpacket  (aso_out0_endofpacket),
        .aso_out0_empty        (aso_out0_empty),
        .status_drop_count     (status_drop_count)
    );

    always #5 clock_clk = ~clock_clk;

    // out_ready only changes just after a rising edge, so the negedge view is the handshake.
    always @(negedge clock_clk)
        if (!reset_reset && aso_out0_valid && aso_out0_ready)
            got.push_back(word_t'({aso_out0_data, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_empty}));

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic beat(input logic [IW-1:0] d, input logic s, input logic e);
        int budget = 0;
        asi_in0_valid         = 1'b1;
        asi_in0_data          = d;
        asi_in0_startofpacket = s;
        asi_in0_endofpacket   = e;
        @(negedge clock_clk);
        while (!asi_in0_ready && budget < 200) begin
            budget++;
            @(negedge clock_clk);
        end
        if (!asi_in0_ready) check("beat_ready_timeout", asi_in0_ready, 1);
        @(posedge clock_clk);
        #1;
        asi_in0_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [IW-1:0] base, input int n);
        for (int i = 0; i < n; i++) beat(base + IW'(i), i == 0, i == n - 1);
    endtask

    function automatic logic [OW-1:0] mk(input logic [IW-1:0] base, input int n);
        logic [OW-1:0] w = '0;
        for (int k = 0; k < n; k++) w[OW-1-k*IW -: IW] = base + IW'(k);
        return w;
    endfunction

    task automatic expect_word(input string tag, input logic [OW-1:0] d, input logic s,
                               input logic e, input logic [EW-1:0] em);
        word_t w;
        if (got.size() == 0) begin
            check({tag, "_count"}, got.size(), 1);
            return;
        end
        w = got.pop_front();
        check({tag, "_data"}, w.data, d);
        check({tag, "_sop"}, w.sop, s);
        check({tag, "_eop"}, w.eop, e);
        check({tag, "_empty"}, w.empty, em);
    endtask

    task automatic drain();
        repeat (4) @(posedge clock_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        @(posedge clock_clk);
        #1;
        reset_reset = 1'b0;
        got.delete();
    endtask

    initial begin
        logic [OW-1:0] w;
        int stalls;
        int budget;
        repeat (2) @(posedge clock_clk);
        #1;
        check("rst_valid", aso_out0_valid, 0);
        check("rst_ready", asi_in0_ready, 1);
        check("rst_drop", status_drop_count, 0);
        check("rst_data", aso_out0_data, 0);
        reset_reset = 1'b0;

        for (int i = 0; i < 7; i++) beat(IW'(i + 1), i == 0, 1'b0);
        check("t1_valid_early", aso_out0_valid, 0);
        beat(32'h8, 1'b0, 1'b1);
        check("t1_latency", aso_out0_valid, 1);
        drain();
        expect_word("t1", 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    1'b1, 1'b1, 3'd0);
        check("t1_extra", got.size(), 0);

        send_pkt(32'h1, 11);
        drain();
        expect_word("t2_w0", 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008,
                    1'b1, 1'b0, 3'd0);
        expect_word("t2_w1", 256'h00000009_0000000a_0000000b_00000000_00000000_00000000_00000000_00000000,
                    1'b0, 1'b1, 3'd5);
        check("t2_extra", got.size(), 0);

        beat(32'h55, 1'b1, 1'b0);
        beat(32'h66, 1'b0, 1'b0);
        reset_reset = 1'b1;
        #2;
        check("mr_valid", aso_out0_valid, 0);
        check("mr_data", aso_out0_data, 0);
        check("mr_sop", aso_out0_startofpacket, 0);
        check("mr_eop", aso_out0_endofpacket, 0);
        check("mr_empty", aso_out0_empty, 0);
        check("mr_drop", status_drop_count, 0);
        check("mr_ready", asi_in0_ready, 1);
        @(posedge clock_clk);
        #1;
        reset_reset = 1'b0;
        drain();
        check("mr_no_output", got.size(), 0);

        beat(32'hDEADBEEF, 1'b1, 1'b1);
        drain();
        w = {32'hDEADBEEF, 224'd0};
        expect_word("t3", w, 1'b1, 1'b1, 3'd7);

        fork
            begin
                send_pkt(32'h10, 8);
                send_pkt(32'h20, 8);
            end
            begin
                budget = 0;
                do begin
                    @(posedge clock_clk);
                    #1;
                    budget++;
                end while (!aso_out0_valid && budget < 100);
                check("t4_first_valid", aso_out0_valid, 1);
                aso_out0_ready = 1'b0;
                stalls = 0;
                repeat (5) begin
                    #1;
                    if (!asi_in0_ready) stalls++;
                    @(posedge clock_clk);
                    #1;
                end
                aso_out0_ready = 1'b1;
                #1;
                check("t4_stall_cycles", stalls, 5);
                check("t4_ready_after", asi_in0_ready, 1);
            end
        join
        drain();
        expect_word("t4_w0", mk(32'h10, 8), 1'b1, 1'b1, 3'd0);
        expect_word("t4_w1", mk(32'h20, 8), 1'b1, 1'b1, 3'd0);
        check("t4_extra", got.size(), 0);

        do_reset();
        repeat (3) beat(32'hBAD0, 1'b0, 1'b0);
        check("t5_drop", status_drop_count, 3);
        check("t5_no_output", got.size(), 0);
        send_pkt(32'h100, 8);
        drain();
        expect_word("t5", mk(32'h100, 8), 1'b1, 1'b1, 3'd0);
        check("t5_drop_after", status_drop_count, 3);

        do_reset();
        beat(32'hA0, 1'b1, 1'b0);
        beat(32'hA1, 1'b0, 1'b0);
        beat(32'hA2, 1'b0, 1'b0);
        send_pkt(32'h200, 8);
        drain();
        check("t6_drop", status_drop_count, 1);
        expect_word("t6", mk(32'h200, 8), 1'b1, 1'b1, 3'd0);
        check("t6_extra", got.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
